// File: rtl/layer_mem_arbiter.sv
// Shares one layer memory port between the compute engine and a host bus.
// The engine has priority, bounded by a host starvation limit and a host burst limit.
module layer_mem_arbiter #(
  parameter int HOST_MAX_BURST = 4,
  parameter int STARVE_LIM     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_cwr,
  input  logic        e_crd,
  input  logic        e_csel,
  input  logic [11:0] e_caddr_wr,
  input  logic [11:0] e_caddr_rd,
  input  logic [12:0] e_cdata_wr,
  output logic [12:0] e_cdata_rd,
  output logic        e_stall,
  input  logic        h_req,
  input  logic        h_we,
  input  logic        h_sel,
  input  logic [11:0] h_addr,
  input  logic [12:0] h_wdata,
  output logic        h_gnt,
  output logic        h_rvalid,
  output logic [12:0] h_rdata,
  output logic        mem_cwr,
  output logic        mem_crd,
  output logic        mem_csel,
  output logic [11:0] mem_caddr_wr,
  output logic [11:0] mem_caddr_rd,
  output logic [12:0] mem_cdata_wr,
  input  logic [12:0] mem_cdata_rd
);

  typedef enum logic {
    ENG_OWN  = 1'b0,
    HOST_OWN = 1'b1
  } state_t;

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIM - 1);
  localparam logic [3:0] BURST_LAST  = 4'(HOST_MAX_BURST - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] starve_cnt;
  logic [3:0] burst_cnt;
  logic       e_req;
  logic       host_view;
  logic       host_rd_gnt;

  assign e_req       = e_cwr | e_crd;
  // Reset forces the engine view onto the outputs even if the state is still HOST_OWN.
  assign host_view   = (state == HOST_OWN) && !reset;
  assign host_rd_gnt = host_view & h_req & ~h_we;
  assign e_cdata_rd  = mem_cdata_rd;

  // Limits compare with >= so a counter that saturated during an unlimited host run still releases.
  always_comb begin
    next_state = state;
    if (state == ENG_OWN) begin
      if (h_req && (!e_req || starve_cnt >= STARVE_LAST))
        next_state = HOST_OWN;
    end else begin
      if (!h_req || (e_req && burst_cnt >= BURST_LAST))
        next_state = ENG_OWN;
    end
  end

  always_comb begin
    mem_cwr      = e_cwr;
    mem_crd      = e_crd;
    mem_csel     = e_csel;
    mem_caddr_wr = e_caddr_wr;
    mem_caddr_rd = e_caddr_rd;
    mem_cdata_wr = e_cdata_wr;
    h_gnt        = 1'b0;
    e_stall      = 1'b0;
    if (host_view) begin
      mem_cwr      = h_req & h_we;
      mem_crd      = h_req & ~h_we;
      mem_csel     = h_sel;
      mem_caddr_wr = h_addr;
      mem_caddr_rd = h_addr;
      mem_cdata_wr = h_wdata;
      h_gnt        = h_req;
      e_stall      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ENG_OWN;
      starve_cnt <= 4'd0;
      burst_cnt  <= 4'd0;
      h_rvalid   <= 1'b0;
      h_rdata    <= 13'd0;
    end else begin
      state    <= next_state;
      h_rvalid <= host_rd_gnt;
      if (host_rd_gnt)
        h_rdata <= mem_cdata_rd;

      if ((state == ENG_OWN && next_state == HOST_OWN) || !h_req)
        starve_cnt <= 4'd0;
      else if (state == ENG_OWN && e_req && starve_cnt != 4'hF)
        starve_cnt <= starve_cnt + 4'd1;

      // Zero for the whole engine-owned period, so every host run starts counting from 0.
      if (state == ENG_OWN || next_state == ENG_OWN)
        burst_cnt <= 4'd0;
      else if (h_req && burst_cnt != 4'hF)
        burst_cnt <= burst_cnt + 4'd1;
    end
  end

endmodule
